// File: rtl/sw_pkg.sv
`default_nettype none
// =============================================================================
// sw_pkg : shared constants and types for the Smith-Waterman query feeder
// Rev 1.0
// =============================================================================
package sw_pkg;

    localparam int SYM_W         = 2;
    localparam int WORD_W        = 32;
    localparam int SYMS_PER_WORD = 16;

    typedef enum logic [1:0] {
        NT_A = 2'd0,
        NT_C = 2'd1,
        NT_G = 2'd2,
        NT_T = 2'd3
    } nucleotide_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/sw_y_feeder.sv
`default_nettype none
// =============================================================================
// sw_y_feeder : pops packed query words, streams one nucleotide per cycle
// Rev 1.0
// =============================================================================
module sw_y_feeder
    import sw_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] seq_len,
    input  logic [31:0]      fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic [1:0]       y_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             underrun_o
);

    localparam int SH    = $clog2(SYMS_PER_WORD);
    localparam int CNT_W = LEN_W - SH + 1;
    localparam int SRC_W = $clog2(SYMS_PER_WORD + 1);

    feeder_state_e     r_state;
    feeder_state_e     w_state_nxt;
    logic [LEN_W-1:0]  r_syms_left;
    logic [CNT_W-1:0]  r_words_left;
    logic [CNT_W-1:0]  w_words_init;
    logic [WORD_W-1:0] r_sr;
    logic [WORD_W-1:0] r_nxt;
    logic [SRC_W-1:0]  r_sr_cnt;
    logic              r_nxt_vld;
    logic              r_rd_pend;
    logic              r_started;
    logic              r_underrun;
    logic              w_emit;
    logic              w_sr_free;
    logic              w_rd;

    assign w_words_init = CNT_W'(seq_len >> SH) + CNT_W'(seq_len[SH-1:0] != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = (r_state == ST_RUN) && (r_sr_cnt != '0) && (r_syms_left != '0);
        w_sr_free   = (r_sr_cnt == '0) || (w_emit && (r_sr_cnt == SRC_W'(1)));
        w_rd        = (r_state == ST_RUN) && (r_words_left != '0) && !fifo_empty
                      && !r_rd_pend && (w_sr_free || !r_nxt_vld);
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = (seq_len == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (w_emit && (r_syms_left == LEN_W'(1))) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        fifo_rd_en = w_rd;
        valid_o    = w_emit;
        y_o        = w_emit ? r_sr[SYM_W-1:0] : '0;
        busy_o     = (r_state != ST_IDLE);
        done_o     = (r_state == ST_DONE);
        underrun_o = r_underrun;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_syms_left  <= '0;
            r_words_left <= '0;
            r_sr         <= '0;
            r_nxt        <= '0;
            r_sr_cnt     <= '0;
            r_nxt_vld    <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_started    <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_pend <= w_rd;
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_syms_left  <= seq_len;
                    r_words_left <= w_words_init;
                    r_underrun   <= 1'b0;
                    r_started    <= 1'b0;
                end
                r_sr_cnt  <= '0;
                r_nxt_vld <= 1'b0;
            end else if (r_state == ST_DONE) begin
                // Leftover symbols of a partial last word are dropped here.
                r_sr_cnt  <= '0;
                r_nxt_vld <= 1'b0;
            end else begin
                if (w_rd) r_words_left <= r_words_left - CNT_W'(1);
                if (w_emit) begin
                    r_syms_left <= r_syms_left - LEN_W'(1);
                    r_started   <= 1'b1;
                end else if (r_started && (r_syms_left != '0)) begin
                    r_underrun <= 1'b1;
                end
                // SR refills from NXT first so word order is preserved.
                if (w_sr_free) begin
                    if (r_nxt_vld) begin
                        r_sr      <= r_nxt;
                        r_sr_cnt  <= SRC_W'(SYMS_PER_WORD);
                        r_nxt_vld <= r_rd_pend;
                        if (r_rd_pend) r_nxt <= fifo_dout;
                    end else if (r_rd_pend) begin
                        r_sr     <= fifo_dout;
                        r_sr_cnt <= SRC_W'(SYMS_PER_WORD);
                    end else begin
                        r_sr_cnt <= '0;
                    end
                end else begin
                    if (w_emit) begin
                        r_sr     <= r_sr >> SYM_W;
                        r_sr_cnt <= r_sr_cnt - SRC_W'(1);
                    end
                    if (r_rd_pend) begin
                        r_nxt     <= fifo_dout;
                        r_nxt_vld <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sw_y_feeder.sv
`default_nettype none
// Randomized bench for sw_y_feeder: a FIFO model feeds the DUT and a
// symbol-queue reference model checks every cycle.
module tb_sw_y_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] seq_len;
    logic [31:0] fifo_dout = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [1:0]  y_o;
    logic        valid_o, busy_o, done_o, underrun_o;

    sw_y_feeder #(.LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .seq_len(seq_len),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .y_o(y_o), .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o),
        .underrun_o(underrun_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    logic [31:0] fifo_q[$];
    logic [31:0] sw_q[$];

    // Reference model: expected symbol list of the current stream.
    logic [1:0] m_exp[$], p_exp[$], obs[$];
    int  m_words = 0, p_words = 0, p_len = 0, m_rd = 0, m_emit = 0, m_k = 0;
    int  m_done_at = -1, m_done_cnt = 0, m_done_cyc = -1;
    bit  m_busy = 1'b0, m_under = 1'b0, m_nogap = 1'b0, p_nogap = 1'b0;
    bit  cmp_idle;
    logic [1:0] cmp_es;

    function automatic void chk(input bit ok, input string name,
                                input longint act, input longint exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) begin
            if (fifo_empty) chk(1'b0 == fifo_empty, "pop_while_empty", fifo_empty, 0);
            else            fifo_dout <= fifo_q.pop_front();
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_idle = !m_busy;
            chk(busy_o == m_busy, "busy_o", busy_o, m_busy);
            chk(underrun_o == m_under, "underrun_o", underrun_o, m_under);
            chk(done_o == (m_busy && cyc == m_done_at), "done_o", done_o,
                (m_busy && cyc == m_done_at));
            if (fifo_rd_en) begin
                m_rd++;
                chk(m_busy && m_rd <= m_words, "rd_bound", m_rd, m_words);
            end
            if (m_nogap && m_busy && m_emit > 0 && m_exp.size() > 0)
                chk(valid_o == 1'b1, "gap_free", valid_o, 1);
            if (valid_o) begin
                chk(m_busy && m_exp.size() != 0, "extra_symbol", m_emit + 1, m_emit);
                if (m_exp.size() != 0) begin
                    cmp_es = m_exp.pop_front();
                    chk(y_o == cmp_es, "y_o", y_o, cmp_es);
                    if (m_emit == 0 && m_nogap)
                        chk(cyc == m_k + 3, "first_sym_cycle", cyc - m_k, 3);
                    m_emit++;
                    obs.push_back(y_o);
                    if (m_exp.size() == 0) m_done_at = cyc + 1;
                end
            end else begin
                chk(y_o == 2'd0, "bubble_y_o", y_o, 0);
                if (m_busy && m_emit > 0 && m_exp.size() > 0) m_under = 1'b1;
            end
            if (done_o) begin
                m_done_cnt++;
                m_done_cyc = cyc;
            end
            if (m_busy && cyc == m_done_at) begin
                chk(m_rd == m_words, "rd_total", m_rd, m_words);
                m_busy = 1'b0;
            end
            if (cmp_idle && start && rst) begin
                m_exp = p_exp;
                m_words = p_words;
                m_nogap = p_nogap;
                m_rd = 0; m_emit = 0; m_done_cnt = 0; m_under = 1'b0;
                m_busy = 1'b1; m_k = cyc;
                m_done_at = (p_len == 0) ? cyc + 1 : -1;
                obs.delete();
            end
        end
    end

    task automatic model_abort();
        m_exp.delete();
        m_busy = 1'b0; m_under = 1'b0; m_nogap = 1'b0; m_done_at = -1;
    endtask

    task automatic set_stream(input int len, input bit nogap);
        p_exp.delete();
        for (int i = 0; i < len; i++)
            p_exp.push_back(2'((sw_q[i / 16] >> (2 * (i % 16))) & 32'd3));
        p_len = len; p_words = (len + 15) / 16; p_nogap = nogap;
    endtask

    task automatic preload(input int n);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) fifo_q.push_back(sw_q[i]);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic flush();
        @(posedge clk); #1;
        fifo_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic go(input int len);
        @(posedge clk); #1;
        start = 1'b1; seq_len = 16'(len);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit pulse);
        int n = 0;
        bit pulsed = 1'b0;
        while (m_busy && n < budget) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (pulse && !pulsed && m_exp.size() > 4) begin
                start = 1'b1;
                seq_len = 16'($urandom_range(1, 200));
                pulsed = 1'b1;
            end
        end
        start = 1'b0;
        chk(!m_busy, "stream_timeout", n, budget);
        chk(m_emit == p_len, "symbol_count", m_emit, p_len);
        chk(m_done_cnt == 1, "done_count", m_done_cnt, 1);
    endtask

    task automatic run_stream(input int len, input int pre, input int dlo,
                              input int dhi, input bit pulse);
        int nw = (len + 15) / 16;
        set_stream(len, pre >= nw);
        preload(pre);
        fork
            go(len);
            begin
                for (int i = pre; i < nw; i++) begin
                    repeat ($urandom_range(dlo, dhi)) @(posedge clk);
                    #1;
                    fifo_q.push_back(sw_q[i]);
                end
            end
        join
        wait_done(600, pulse);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt, n, len, nw;
        rst = 1'b0; start = 1'b0; seq_len = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(valid_o == 0, "reset_valid_o", valid_o, 0);
        chk(busy_o == 0, "reset_busy_o", busy_o, 0);
        chk(done_o == 0, "reset_done_o", done_o, 0);
        chk(fifo_rd_en == 0, "reset_rd_en", fifo_rd_en, 0);
        chk(underrun_o == 0 && y_o == 0, "reset_underrun_y", {underrun_o, y_o}, 0);
        rst = 1'b1;
        chk_en = 1'b1;

        // One full word, repeating A,C,G,T.
        sw_q = '{32'hE4E4E4E4};
        run_stream(16, 1, 1, 1, 1'b0);
        chk(m_done_cyc - m_k == 19, "t1_done_cycle", m_done_cyc - m_k, 19);
        chk(m_rd == 1, "t1_reads", m_rd, 1);
        chk(underrun_o == 0, "t1_underrun", underrun_o, 0);
        chk(obs.size() == 16, "t1_obs_len", obs.size(), 16);
        for (int i = 0; i < obs.size(); i++)
            chk(obs[i] == 2'(i % 4), "t1_symbol", obs[i], i % 4);

        // Three words plus a spare that must not be popped.
        sw_q = '{32'h00000000, 32'hFFFFFFFF, 32'h0000AAAA, 32'h12345678};
        run_stream(40, 4, 1, 1, 1'b0);
        chk(m_rd == 3, "t2_reads", m_rd, 3);
        chk(fifo_q.size() == 1, "t2_fifo_left", fifo_q.size(), 1);
        chk(obs.size() == 40, "t2_obs_len", obs.size(), 40);
        if (obs.size() == 40) begin
            chk(obs[0] == 2'd0, "t2_sym0", obs[0], 0);
            chk(obs[16] == 2'd3, "t2_sym16", obs[16], 3);
            chk(obs[39] == 2'd2, "t2_sym39", obs[39], 2);
        end
        flush();

        // Starved second word.
        sw_q = '{32'h9C3A5F71, 32'h0BADF00D};
        run_stream(32, 1, 20, 20, 1'b0);
        chk(underrun_o == 1, "t3_underrun", underrun_o, 1);

        // Zero length with data waiting in the FIFO.
        sw_q = '{32'hDEADBEEF};
        run_stream(0, 1, 1, 1, 1'b0);
        chk(m_done_cyc - m_k == 1, "t4_done_cycle", m_done_cyc - m_k, 1);
        chk(m_rd == 0, "t4_reads", m_rd, 0);
        flush();

        // Reset during the fifth symbol.
        sw_q = '{32'h11111111, 32'h22222222, 32'hC6A5E41B};
        set_stream(48, 1'b1);
        preload(3);
        go(48);
        cnt = 0; n = 0;
        while (cnt < 5 && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (valid_o) cnt++;
        end
        chk(cnt == 5, "t5_reach_sym5", cnt, 5);
        rst = 1'b0;
        @(posedge clk); #1;
        model_abort();
        chk({valid_o, y_o, busy_o, done_o, fifo_rd_en, underrun_o} == 7'd0,
            "t5_outputs_after_reset", {valid_o, y_o, busy_o, done_o, fifo_rd_en, underrun_o}, 0);
        rst = 1'b1;
        chk(fifo_q.size() == 1, "t5_fifo_left", fifo_q.size(), 1);
        sw_q = '{32'hC6A5E41B};
        set_stream(16, 1'b1);
        go(16);
        wait_done(600, 1'b0);

        // Restart attempt mid-stream.
        sw_q = '{32'h01234567, 32'h89ABCDEF};
        run_stream(32, 2, 1, 1, 1'b1);

        // Randomized streams.
        for (int r = 0; r < 10; r++) begin
            len = $urandom_range(1, 70);
            nw = (len + 15) / 16;
            sw_q.delete();
            for (int i = 0; i < nw; i++) sw_q.push_back($urandom);
            run_stream(len, $urandom_range(0, nw), 1, 25, r[0]);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sw_y_feeder.md
# sw_y_feeder

Upstream feeder for the Smith-Waterman systolic PE array. Pops 32-bit packed query words (16 × 2-bit nucleotides) from the 32×512 sequence FIFO. Unpacks them LSB-first and drives one symbol per cycle with a valid strobe into the `Y_i`/`valid_i` inputs of the first PE. Double-buffers one word so a non-empty FIFO gives a gap-free symbol stream; FIFO starvation produces bubbles (`valid_o` low), which the array tolerates.

## Interface

- `LEN_W`, 16: width of the symbol-count input; max query length 2^LEN_W − 1.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-low reset; `rst` = 0 at a rising edge resets the block.
- `start` in 1: begin a stream; sampled only in IDLE.
- `seq_len` in LEN_W: number of symbols to emit; sampled with `start`.
- `fifo_dout` in 32: FIFO read data; valid the cycle after `fifo_rd_en`.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_en` out 1: FIFO pop request.
- `y_o` out 2: current nucleotide, to the first PE `Y_i`.
- `valid_o` out 1: `y_o` valid, to the first PE `valid_i`.
- `busy_o` out 1: high from the cycle after an accepted `start` through the `done_o` cycle.
- `done_o` out 1: one-cycle pulse after the last symbol.
- `underrun_o` out 1: sticky; set on any mid-stream bubble, cleared by the next accepted `start` or by reset.

## Operation

- **Reset values:** all outputs 0, state IDLE, counters 0, both word buffers marked empty.
- **States:**
  - IDLE: on `start` with `seq_len` ≠ 0, go to RUN and load `syms_left` = `seq_len` and `words_left` = ceil(`seq_len`/16). On `start` with `seq_len` = 0, go to DONE.
  - RUN: fetch and emit. When the last symbol is emitted, go to DONE.
  - DONE: pulse `done_o` for one cycle, then return to IDLE.
- **Fetch rule:** `fifo_rd_en` = 1 iff all of the following hold:
  - state is RUN;
  - `words_left` > 0;
  - `fifo_empty` = 0;
  - no read is in flight (no `rd_en` in the previous cycle);
  - at least one buffer (shift register SR or next-word register NXT) is empty, or will be freed this cycle.
- **Word counting:** each issued read decrements `words_left`. No read is ever issued beyond ceil(`seq_len`/16) words, and the FIFO is never popped while empty.
- **Capture:** returning data goes into SR if SR is empty or empties this cycle; otherwise it goes into NXT.
- **Emit:**
  - When SR holds a word and `syms_left` > 0, present `y_o` = SR[1:0] with `valid_o` = 1, then shift SR right by 2 and decrement `syms_left`.
  - After 16 symbols, SR reloads from NXT (or from capture data) with no bubble.
- **Partial last word:** only `syms_left` symbols are emitted from it; the upper symbols are discarded.
- **Bubble:** when `valid_o` = 0, `y_o` = 0. A bubble with `syms_left` > 0 in RUN sets `underrun_o`.
- **Other boundaries:**
  - `start` while busy is ignored.
  - Reset mid-stream returns the block to IDLE immediately. Words already popped are lost; the FIFO is not flushed.

## Timing

- `start` high in cycle k (IDLE, FIFO non-empty):
  - `fifo_rd_en` high in cycle k+1;
  - word captured at the end of k+2;
  - first `valid_o` in cycle k+3.
- Second-word `rd_en` no later than k+3, so symbol 16 follows symbol 15 with no gap whenever the FIFO stays non-empty.
- Last symbol in cycle m → `done_o` = 1 in m+1, `busy_o` falls in m+2.
- `seq_len` = 0: `done_o` in k+1, no `fifo_rd_en` at any point.
- Throughput: 1 symbol/cycle; at most one read per 2 cycles, which is sufficient because a word lasts 16 cycles.

## Structure

- Shared package `sw_pkg` holds:
  - `SYM_W` = 2, `WORD_W` = 32, `SYMS_PER_WORD` = 16;
  - nucleotide encoding A=0, C=1, G=2, T=3;
  - the feeder state enum (IDLE/RUN/DONE).
- Single module with no sub-module; SR, NXT and the counters stay inline.

## Test plan

- `seq_len`=16, FIFO holds 0xE4E4E4E4 → `y_o` = 0,1,2,3 repeated 4 times over 16 consecutive valid cycles starting at k+3; exactly one `rd_en`; `done_o` at k+19; `underrun_o` = 0.
- `seq_len`=40, three words preloaded (0x00000000, 0xFFFFFFFF, 0x0000AAAA) → 40 contiguous valid cycles: 16×0, 16×3, 8×2; exactly 3 `rd_en`; no fourth pop.
- `seq_len`=32, one word preloaded, second word pushed 20 cycles after `start` → bubble cycles with `valid_o`=0 and `y_o`=0; `underrun_o`=1; 32 valid symbols in total; `done_o` once.
- `seq_len`=0 → `done_o` at k+1, `busy_o` never high beyond the DONE cycle, `fifo_rd_en` never high.
- `rst`=0 during the 5th symbol → next cycle all outputs 0 and state IDLE; a subsequent `start` with `seq_len`=16 streams correctly from the next FIFO word.
- `start` pulsed again mid-stream with a different `seq_len` → ignored; original symbol count and single `done_o` preserved.
